// File: rtl/ifmap_pingpong_loader.sv
// Ifmap stream loader: drains a FIFO-style stream into NUM_BANKS SRAM banks used round-robin.
// Optional macro IFSTORE_ROW_DONE_EN adds row_done_dout / row_idx_dout per-row completion outputs.
module ifmap_pingpong_loader #(
    parameter int TBITS     = 64,
    parameter int ADDR_BITS = 11,
    parameter int NUM_BANKS = 2,
    parameter int BANK_BITS = 1,
    parameter int CFG_BITS  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_if_store,
    input  logic [CFG_BITS-1:0]  cfg_row_words,
    input  logic [3:0]           cfg_num_rows,
    input  logic [TBITS-1:0]     ifstore_data_din,
    input  logic                 ifstore_empty_n_din,
    output logic                 ifstore_read_dout,
    output logic                 if_store_busy,
    output logic                 if_store_done,
    output logic                 cfg_err_dout,
    output logic [BANK_BITS-1:0] bank_sel_dout,
    output logic [NUM_BANKS-1:0] bank_full_dout,
    input  logic [NUM_BANKS-1:0] bank_release_din,
`ifdef IFSTORE_ROW_DONE_EN
    output logic                 row_done_dout,
    output logic [3:0]           row_idx_dout,
`endif
    output logic [NUM_BANKS-1:0] sram_cen_dout,
    output logic [NUM_BANKS-1:0] sram_wen_dout,
    output logic [ADDR_BITS-1:0] sram_addr_dout,
    output logic [TBITS-1:0]     sram_data_dout
);

    localparam int TOT_BITS = CFG_BITS + 4;
    localparam int DEPTH    = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BANK,
        S_LOAD,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [TOT_BITS-1:0]  w_total;
    logic [TOT_BITS-1:0]  r_total;
    logic [CFG_BITS-1:0]  r_wcnt;
    logic                 r_cfg_err;
    logic [BANK_BITS-1:0] r_bank_sel;
    logic [BANK_BITS-1:0] w_bank_nxt;
    logic [NUM_BANKS-1:0] r_bank_full;
    logic [NUM_BANKS-1:0] w_bank_onehot;
    logic [NUM_BANKS-1:0] r_cen;
    logic [ADDR_BITS-1:0] r_addr;
    logic [TBITS-1:0]     r_data;

    logic w_cfg_bad;
    logic w_accept;
    logic w_read;
    logic w_xfer;
    logic w_last;
    logic w_load_entry;

    assign w_total       = TOT_BITS'(cfg_row_words) * TOT_BITS'(cfg_num_rows);
    assign w_cfg_bad     = (w_total == '0) || (w_total > TOT_BITS'(DEPTH));
    assign w_accept      = (r_state == S_IDLE) && start_if_store && !w_cfg_bad;

    // Read strobe comes straight from registers so the stream is never over-read.
    assign w_read        = (r_state == S_LOAD) && (TOT_BITS'(r_wcnt) != r_total);
    assign w_xfer        = w_read && ifstore_empty_n_din;
    assign w_last        = w_xfer && ((TOT_BITS'(r_wcnt) + TOT_BITS'(1)) == r_total);

    assign w_bank_onehot = NUM_BANKS'(1) << r_bank_sel;
    assign w_bank_nxt    = (r_bank_sel == BANK_BITS'(NUM_BANKS - 1)) ? '0
                                                                    : r_bank_sel + BANK_BITS'(1);
    assign w_load_entry  = (r_state != S_LOAD) && (w_state_nxt == S_LOAD);

    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = r_bank_full[r_bank_sel] ? S_WAIT_BANK : S_LOAD;
                end
            end
            S_WAIT_BANK: begin
                if (!r_bank_full[r_bank_sel]) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total     <= '0;
            r_wcnt      <= '0;
            r_cfg_err   <= 1'b0;
            r_bank_sel  <= '0;
            r_bank_full <= '0;
        end else begin
            // Any start seen in IDLE re-evaluates the error flag; a good one also latches the size.
            if ((r_state == S_IDLE) && start_if_store) begin
                r_cfg_err <= w_cfg_bad;
                if (!w_cfg_bad) begin
                    r_total <= w_total;
                end
            end

            if (w_load_entry) begin
                r_wcnt <= '0;
            end else if (w_xfer) begin
                r_wcnt <= r_wcnt + CFG_BITS'(1);
            end

            if (r_state == S_DONE) begin
                r_bank_sel <= w_bank_nxt;
            end

            // Set is OR-ed after the release mask, so a same-cycle set wins.
            r_bank_full <= (r_bank_full & ~bank_release_din)
                         | ((r_state == S_DONE) ? w_bank_onehot : '0);
        end
    end

    // Write port: one-cycle latency from the stream transfer to the SRAM strobe.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: address/data flops are reset too, so the SRAM bus is quiet and known out of reset.
        if (!reset) begin
            r_cen  <= '1;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_xfer) begin
            r_cen  <= ~w_bank_onehot;
            r_addr <= r_wcnt[ADDR_BITS-1:0];
            r_data <= ifstore_data_din;
        end else begin
            r_cen  <= '1;
        end
    end

`ifdef IFSTORE_ROW_DONE_EN
    logic [CFG_BITS-1:0] r_row_words;
    logic [CFG_BITS-1:0] r_col;
    logic [3:0]          r_row_cnt;
    logic [3:0]          r_row_idx;
    logic                r_row_done;

    // Row pulse is registered on the same edge as the write strobe, so both appear together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_words <= '0;
            r_col       <= '0;
            r_row_cnt   <= '0;
            r_row_idx   <= '0;
            r_row_done  <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            if (w_accept) begin
                r_row_words <= cfg_row_words;
            end
            if (w_load_entry) begin
                r_col     <= '0;
                r_row_cnt <= '0;
            end else if (w_xfer) begin
                if (r_col == (r_row_words - CFG_BITS'(1))) begin
                    r_col      <= '0;
                    r_row_cnt  <= r_row_cnt + 4'd1;
                    r_row_idx  <= r_row_cnt;
                    r_row_done <= 1'b1;
                end else begin
                    r_col <= r_col + CFG_BITS'(1);
                end
            end
        end
    end

    assign row_done_dout = r_row_done;
    assign row_idx_dout  = r_row_idx;
`endif

    assign ifstore_read_dout = w_read;
    assign if_store_busy     = (r_state == S_WAIT_BANK) || (r_state == S_LOAD);
    assign if_store_done     = (r_state == S_DONE);
    assign cfg_err_dout      = r_cfg_err;
    assign bank_sel_dout     = r_bank_sel;
    assign bank_full_dout    = r_bank_full;
    assign sram_cen_dout     = r_cen;
    assign sram_wen_dout     = r_cen;
    assign sram_addr_dout    = r_addr;
    assign sram_data_dout    = r_data;

endmodule
